// File: rtl/pixel_rx_assembler_pkg.sv
// Shared types and constants for the UART pixel assembler.
// Byte A carries {R,G}; the high nibble of byte B carries B.
package pixel_rx_assembler_pkg;

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } rxState_e;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  localparam int COL_W = $clog2(IMG_W_DEF);
  localparam int ROW_W = $clog2(IMG_H_DEF);

  localparam int A_R_HI = 7;
  localparam int A_R_LO = 4;
  localparam int A_G_HI = 3;
  localparam int A_G_LO = 0;
  localparam int B_B_HI = 7;
  localparam int B_B_LO = 4;

endpackage

// File: rtl/pixel_rx_assembler.sv
// Pairs UART bytes into 12-bit RGB pixels and tags them
// with raster position for the 3x3 convolution stage.
module pixel_rx_assembler
  import pixel_rx_assembler_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             frame_sync,
  output logic [11:0]      datainRGB,
  output logic             pixel_rdy,
  output logic             num_pix_ok,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             frame_done,
  output logic             err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  rxState_e        state;
  logic [7:0]      rgLatch;
  logic [TO_W-1:0] toCnt;
  logic [COL_W-1:0] posCol;
  logic [ROW_W-1:0] posRow;

  logic lastCol;
  logic lastRow;
  logic winOk;

  assign lastCol = (posCol == COL_LAST);
  assign lastRow = (posRow == ROW_LAST);
  assign winOk   = (posRow >= ROW_W'(2)) &&
                   (posCol >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_A;
      rgLatch     <= '0;
      toCnt       <= '0;
      posCol      <= '0;
      posRow      <= '0;
      datainRGB   <= '0;
      pixel_rdy   <= 1'b0;
      num_pix_ok  <= 1'b0;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pixel_rdy   <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      // sync wins, but a coincident byte still starts the new frame
      if (frame_sync) begin
        posCol <= '0;
        posRow <= '0;
        toCnt  <= '0;
        if (rx_valid) begin
          rgLatch <= rx_data;
          state   <= WAIT_B;
        end else begin
          state <= WAIT_A;
        end
      end else begin
        unique case (state)
          WAIT_A: begin
            if (rx_valid) begin
              rgLatch <= rx_data;
              toCnt   <= '0;
              state   <= WAIT_B;
            end
          end
          WAIT_B: begin
            if (rx_valid) begin
              datainRGB <= {rgLatch[A_R_HI:A_R_LO],
                            rgLatch[A_G_HI:A_G_LO],
                            rx_data[B_B_HI:B_B_LO]};
              pixel_rdy  <= 1'b1;
              col        <= posCol;
              row        <= posRow;
              num_pix_ok <= winOk;
              state      <= WAIT_A;
              if (lastCol) begin
                posCol <= '0;
                if (lastRow) begin
                  posRow     <= '0;
                  frame_done <= 1'b1;
                end else begin
                  posRow <= posRow + 1'b1;
                end
              end else begin
                posCol <= posCol + 1'b1;
              end
            end else if (toCnt == TO_MAX) begin
              err_timeout <= 1'b1;
              toCnt       <= '0;
              state       <= WAIT_A;
            end else begin
              toCnt <= toCnt + 1'b1;
            end
          end
          default: state <= WAIT_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_rx_assembler.sv
// Self-checking bench: vector table, random raster stream
// against an index-based model, and hand-written corner cases.
module tb_pixel_rx_assembler;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_sync;
  logic [11:0] datainRGB;
  logic        pixel_rdy;
  logic        num_pix_ok;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        frame_done;
  logic        err_timeout;

  int nTests = 0;
  int nFail  = 0;
  int rdyCount = 0;
  int errCount = 0;

  pixel_rx_assembler #(
    .IMG_W(W), .IMG_H(H), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_sync(frame_sync),
    .datainRGB(datainRGB), .pixel_rdy(pixel_rdy),
    .num_pix_ok(num_pix_ok), .col(col), .row(row),
    .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pixel_rdy) rdyCount++;
    if (err_timeout) errCount++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(string name, int act, int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sendByte(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic doSync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic checkPix(string name, int rgb,
                          int c, int r, int ok, int fd);
    check({name, ".rdy"}, int'(pixel_rdy), 1);
    check({name, ".rgb"}, int'(datainRGB), rgb);
    check({name, ".col"}, int'(col), c);
    check({name, ".row"}, int'(row), r);
    check({name, ".ok"}, int'(num_pix_ok), ok);
    check({name, ".fd"}, int'(frame_done), fd);
  endtask

  task automatic checkZero(string name);
    check({name, ".rdy"}, int'(pixel_rdy), 0);
    check({name, ".rgb"}, int'(datainRGB), 0);
    check({name, ".col"}, int'(col), 0);
    check({name, ".row"}, int'(row), 0);
    check({name, ".ok"}, int'(num_pix_ok), 0);
    check({name, ".fd"}, int'(frame_done), 0);
    check({name, ".err"}, int'(err_timeout), 0);
  endtask

  initial begin
    int errBase;
    int rdyBase;
    logic [7:0] a;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 8'h3F, 12'hA53};
    vecs[1] = '{8'h00, 8'hF0, 12'h00F};
    vecs[2] = '{8'hFF, 8'h0F, 12'hFF0};
    vecs[3] = '{8'h5A, 8'hC3, 12'h5AC};
    vecs[4] = '{8'h81, 8'h7E, 12'h817};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    frame_sync = 1'b0;
    idle(2);
    rst = 1'b0;
    checkZero("reset");

    // table vectors along row 0
    for (int k = 0; k < 5; k++) begin
      sendByte(vecs[k].a);
      check("vec.early", int'(pixel_rdy), 0);
      sendByte(vecs[k].b);
      checkPix($sformatf("vec%0d", k),
               int'(vecs[k].rgb), k, 0, 0, 0);
    end
    tick();
    check("hold.rdy", int'(pixel_rdy), 0);
    check("hold.rgb", int'(datainRGB), 12'h817);
    check("hold.col", int'(col), 4);

    // random raster stream, a bit over one frame
    doSync();
    errBase = errCount;
    for (int i = 0; i < W * H + 3; i++) begin
      int c;
      int r;
      int okE;
      int fdE;
      a = 8'($urandom);
      b = 8'($urandom);
      idle($urandom_range(0, 3));
      sendByte(a);
      idle($urandom_range(0, 3));
      sendByte(b);
      c = i % W;
      r = (i / W) % H;
      okE = (r >= 2 && c >= 2) ? 1 : 0;
      fdE = ((i % (W * H)) == W * H - 1) ? 1 : 0;
      checkPix($sformatf("rnd%0d", i),
               int'({a, b[7:4]}), c, r, okE, fdE);
    end
    check("rnd.noerr", errCount, errBase);

    // timeout after byte A
    doSync();
    sendByte(8'h44);
    sendByte(8'h50);
    checkPix("to.pre", 12'h445, 0, 0, 0, 0);
    sendByte(8'h99);
    for (int i = 1; i < TO; i++) begin
      tick();
      if (err_timeout) begin
        nTests++;
        nFail++;
        $display("FAIL to.early: err at idle %0d", i);
      end
    end
    tick();
    check("to.err", int'(err_timeout), 1);
    tick();
    check("to.errpulse", int'(err_timeout), 0);
    sendByte(8'h12);
    sendByte(8'h30);
    checkPix("to.post", 12'h123, 1, 0, 0, 0);

    // byte B lands on the cycle the timeout would fire
    errBase = errCount;
    sendByte(8'hBC);
    idle(TO - 1);
    sendByte(8'hD0);
    checkPix("race", 12'hBCD, 2, 0, 0, 0);
    tick();
    check("race.noerr", errCount, errBase);

    // sync coincident with a byte starts a new pixel
    errBase = errCount;
    sendByte(8'hEE);
    frame_sync = 1'b1;
    sendByte(8'h77);
    frame_sync = 1'b0;
    check("sync.norpix", int'(pixel_rdy), 0);
    sendByte(8'h80);
    checkPix("sync", 12'h778, 0, 0, 0, 0);
    idle(TO + 2);
    check("sync.noerr", errCount, errBase);

    // reset between bytes discards the partial pixel
    sendByte(8'h21);
    sendByte(8'h30);
    sendByte(8'h66);
    rdyBase = rdyCount;
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hF0;
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    checkZero("rstmid");
    tick();
    check("rstmid.nopix", rdyCount, rdyBase);
    sendByte(8'h9A);
    sendByte(8'hB0);
    checkPix("rstmid.next", 12'h9AB, 0, 0, 0, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end

endmodule

// File: doc/pixel_rx_assembler.md
PIXEL_RX_ASSEMBLER -- requirements
Module: pixel_rx_assembler

Interface
REQ-001 Parameter IMG_W, default 640, pixels per image row.
REQ-002 Parameter IMG_H, default 480, rows per frame.
REQ-003 Parameter TIMEOUT, default 100000, max clk cycles allowed between the first and second byte of one pixel.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_data  input  8  byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 frame_sync  input  1  one-cycle strobe; start of a new frame.
REQ-009 datainRGB  output  12  assembled pixel {R,G,B}, 4 bits each.
REQ-010 pixel_rdy  output  1  one-cycle strobe; datainRGB valid.
REQ-011 num_pix_ok  output  1  pixel completes a full 3x3 window.
REQ-012 col  output  10  column index of the pixel on datainRGB.
REQ-013 row  output  9  row index of the pixel on datainRGB.
REQ-014 frame_done  output  1  one-cycle strobe with the last pixel of a frame.
REQ-015 err_timeout  output  1  one-cycle strobe; partial pixel discarded.

Function
REQ-016 Byte format: byte A = {R[3:0],G[3:0]}; byte B = {B[3:0],xxxx}; the low nibble of byte B is ignored.
REQ-017 FSM states: WAIT_A, WAIT_B.
REQ-018 In WAIT_A, rx_valid latches rx_data[7:0] as {R,G} and moves to WAIT_B.
REQ-019 In WAIT_B, rx_valid moves to WAIT_A.
REQ-020 On that same WAIT_B rx_valid, the cycle after it drives datainRGB = {R,G,rx_data[7:4]} with pixel_rdy=1 for exactly one cycle.
REQ-021 Latency from the byte-B rx_valid to pixel_rdy is exactly 1 cycle.
REQ-022 datainRGB, col, row and num_pix_ok hold their values between pixel_rdy strobes.
REQ-023 col and row on a pixel_rdy cycle give that pixel's position; first pixel of a frame = (0,0).
REQ-024 Internal position advances after each emitted pixel: col increments; at col=IMG_W-1, col wraps to 0 and row increments.
REQ-025 At col=IMG_W-1 and row=IMG_H-1, frame_done=1 in the same cycle as pixel_rdy, and the position wraps to (0,0).
REQ-026 num_pix_ok=1 on a pixel_rdy cycle iff row>=2 and col>=2; it is 0 otherwise.
REQ-027 A timeout counter runs only in WAIT_B and clears on entering WAIT_B.
REQ-028 If the timeout counter reaches TIMEOUT with no rx_valid, err_timeout pulses for 1 cycle, the partial byte is discarded, and the FSM returns to WAIT_A; position is unchanged.
REQ-029 frame_sync clears the FSM to WAIT_A, the position to (0,0), and the timeout counter, and discards any partial pixel without flagging err_timeout.
REQ-030 frame_sync and rx_valid in the same cycle: sync is applied first, and the byte is taken as byte A of the new frame.
REQ-031 rx_valid on the exact cycle the timeout fires: the timeout is ignored, and the byte completes the pixel normally.

Reset
REQ-032 rst overrides all inputs; takes effect on the next rising clk edge.
REQ-033 rst sets FSM=WAIT_A; datainRGB=0, pixel_rdy=0, num_pix_ok=0, col=0, row=0, frame_done=0, err_timeout=0; position and timeout counter cleared.
REQ-034 rst mid-pixel discards the partial byte, and no strobe is generated for it.

Structure
REQ-035 A shared package holds the FSM state enum, default IMG_W/IMG_H, the byte-format field positions, and the col/row widths derived as clog2 of IMG_W/IMG_H.
REQ-036 Single module, no sub-modules.
REQ-037 Output feeds the downstream 3x3 convolution stage directly (datainRGB, pixel_rdy, num_pix_ok).

Verification
REQ-038 Reset, then bytes 0xA5, 0x3F -> one cycle later datainRGB=0xA53, pixel_rdy=1 for 1 cycle, col=0, row=0, num_pix_ok=0.
REQ-039 Stream 2*IMG_W+3 pixels -> num_pix_ok=0 through pixel index 2*IMG_W+1 (row 2, col 1), and =1 at row 2, col 2.
REQ-040 Stream IMG_W*IMG_H pixels -> frame_done=1 only with the pixel at (IMG_W-1, IMG_H-1); the next pixel reports (0,0).
REQ-041 Byte A then TIMEOUT idle cycles -> err_timeout pulse; the next two bytes 0x12, 0x30 yield datainRGB=0x123 at unchanged col/row.
REQ-042 Byte A, then frame_sync coincident with byte 0x77, then byte 0x80 -> pixel 0x778 at (0,0); no err_timeout.
REQ-043 rst asserted between byte A and byte B -> no pixel_rdy; all outputs 0; the next two bytes form a pixel at (0,0).
